// File: rtl/commit_burst_arb_pkg.sv
// Shared types for the commit burst arbiter: FSM state, packet struct and index-width helper.
package commit_burst_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } commit_arb_state_e;

    // Widest payload the packet register can carry; DATAW must not exceed it.
    localparam int unsigned CommitDataW = 64;

    typedef struct packed {
        logic [CommitDataW-1:0] data;
        logic                   sop;
        logic                   eop;
    } commit_pkt_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/commit_burst_arb_if.sv
// Requester-side and commit-side bus of the commit burst arbiter.
interface commit_burst_arb_if #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 64
);
    localparam int unsigned IDXW = commit_burst_arb_pkg::idx_width(NUM_REQS);

    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       sop_in;
    logic [NUM_REQS-1:0]       eop_in;
    logic [NUM_REQS-1:0]       ready_in;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic                      sop_out;
    logic                      eop_out;
    logic                      ready_out;
    logic [IDXW-1:0]           sel_out;
    logic                      locked;

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_out,
        output ready_in, valid_out, data_out, sop_out, eop_out, sel_out, locked
    );

    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_out,
        input  ready_in, valid_out, data_out, sop_out, eop_out, sel_out, locked
    );

endinterface

// File: rtl/starve_counter.sv
// Saturating wait counter; sat flags a requester that has waited STARVE_LIMIT cycles.
module starve_counter #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat
);
    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q;

    assign sat = (cnt_q == CntW'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/commit_burst_arb.sv
// Commit-lane arbiter with sop..eop burst locking, starvation promotion and a registered output.
module commit_burst_arb
    import commit_burst_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATAW        = 64,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input logic               clk,
    input logic               reset,
    commit_burst_arb_if.slave bus
);
    localparam int unsigned IDXW = idx_width(NUM_REQS);

    commit_arb_state_e   state_q, state_d;
    logic [IDXW-1:0]     lock_idx_q, lock_idx_d;
    logic [NUM_REQS-1:0] sat, fire_vec, ready_vec;
    logic [IDXW-1:0]     idle_idx, grant_idx;
    logic                idle_any, can_load, fire;
    logic                grant_valid, grant_sop, grant_eop;
    logic [DATAW-1:0]    grant_data;
    commit_pkt_t         pkt_q;
    logic                valid_q;
    logic [IDXW-1:0]     sel_q;

    assign can_load = !valid_q || bus.ready_out;

    // Lowest valid index, overridden by the lowest saturated one; counters are pre-update.
    always_comb begin
        idle_idx = '0;
        idle_any = 1'b0;
        for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
            if (bus.valid_in[i]) begin
                idle_idx = IDXW'(i);
                idle_any = 1'b1;
            end
        end
        for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
            if (bus.valid_in[i] && sat[i]) begin
                idle_idx = IDXW'(i);
            end
        end
    end

    assign grant_idx = (state_q == StLocked) ? lock_idx_q : idle_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            StIdle: begin
                if (fire && grant_sop && !grant_eop) begin
                    state_d    = StLocked;
                    lock_idx_d = grant_idx;
                end
            end
            StLocked: begin
                if (fire && grant_eop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_vec   = '0;
        grant_valid = 1'b0;
        grant_sop   = 1'b0;
        grant_eop   = 1'b0;
        grant_data  = '0;
        bus.locked  = (state_q == StLocked);
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (IDXW'(i) == grant_idx) begin
                grant_valid  = bus.valid_in[i];
                grant_sop    = bus.sop_in[i];
                grant_eop    = bus.eop_in[i];
                grant_data   = bus.data_in[i*DATAW +: DATAW];
                ready_vec[i] = can_load && ((state_q == StLocked) || idle_any);
            end
        end
    end

    assign fire         = grant_valid && can_load;
    assign fire_vec     = bus.valid_in & ready_vec;
    assign bus.ready_in = ready_vec;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_starve
        starve_counter #(
            .LIMIT(STARVE_LIMIT)
        ) u_starve_counter (
            .clk  (clk),
            .reset(reset),
            .clr  (fire_vec[i]),
            .inc  (bus.valid_in[i] && !fire_vec[i]),
            .sat  (sat[i])
        );

        sop_mid_burst: assert property (@(posedge clk) disable iff (reset)
            (state_q == StLocked && lock_idx_q == IDXW'(i) && bus.valid_in[i]) |-> !bus.sop_in[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
            sel_q   <= '0;
        end else if (fire) begin
            valid_q <= 1'b1;
            pkt_q   <= '{data: CommitDataW'(grant_data), sop: grant_sop, eop: grant_eop};
            sel_q   <= grant_idx;
        end else if (bus.ready_out) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = pkt_q.data[DATAW-1:0];
    assign bus.sop_out   = pkt_q.sop;
    assign bus.eop_out   = pkt_q.eop;
    assign bus.sel_out   = sel_q;

    ready_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(ready_vec));

endmodule

// File: tb/tb_commit_burst_arb.sv
// Directed bench for commit_burst_arb: a 4-requester instance and a 1-requester instance.
module tb_commit_burst_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    commit_burst_arb_if #(.NUM_REQS(4), .DATAW(64)) bus_a ();
    commit_burst_arb_if #(.NUM_REQS(1), .DATAW(64)) bus_b ();

    commit_burst_arb #(
        .NUM_REQS(4), .DATAW(64), .STARVE_LIMIT(15)
    ) u_dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    commit_burst_arb #(
        .NUM_REQS(1), .DATAW(64), .STARVE_LIMIT(1)
    ) u_dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic s, input logic e,
                           input logic [63:0] d);
        bus_a.valid_in[i]         = v;
        bus_a.sop_in[i]           = s;
        bus_a.eop_in[i]           = e;
        bus_a.data_in[i*64 +: 64] = d;
    endtask

    task automatic clear_inputs();
        bus_a.valid_in  = '0;
        bus_a.sop_in    = '0;
        bus_a.eop_in    = '0;
        bus_a.data_in   = '0;
        bus_a.ready_out = 1'b1;
        bus_b.valid_in  = '0;
        bus_b.sop_in    = '0;
        bus_b.eop_in    = '0;
        bus_b.data_in   = '0;
        bus_b.ready_out = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus_a.valid_out !== 1'b0 || bus_a.locked !== 1'b0 || bus_a.sel_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl valid=%b locked=%b sel=%0d, want 0 0 0",
                     bus_a.valid_out, bus_a.locked, bus_a.sel_out);
        end
        checks++;
        if (bus_a.data_out !== 64'd0 || bus_a.sop_out !== 1'b0 || bus_a.eop_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_data data=%h sop=%b eop=%b, want 0 0 0",
                     bus_a.data_out, bus_a.sop_out, bus_a.eop_out);
        end
        checks++;
        if (bus_a.ready_in !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got=%b want=0000", bus_a.ready_in);
        end
    endtask

    // Req2 waits behind req0 for 15 cycles, then wins once on the saturated counter.
    task automatic test_starvation();
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_sel;
        logic [63:0] exp_dat;
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b1, 64'hA0);
        set_req(2, 1'b1, 1'b1, 1'b1, 64'hA2);
        for (int k = 0; k < 17; k++) begin
            exp_rdy = (k == 15) ? 4'b0100 : 4'b0001;
            exp_sel = (k == 15) ? 2'd2 : 2'd0;
            exp_dat = (k == 15) ? 64'hA2 : 64'hA0;
            #1;
            checks++;
            if (bus_a.ready_in !== exp_rdy) begin
                errors++;
                $display("FAIL starve_ready k=%0d got=%b want=%b", k, bus_a.ready_in, exp_rdy);
            end
            tick();
            checks++;
            if (bus_a.valid_out !== 1'b1 || bus_a.sel_out !== exp_sel ||
                bus_a.data_out !== exp_dat) begin
                errors++;
                $display("FAIL starve_out k=%0d valid=%b sel=%0d data=%h want 1 %0d %h",
                         k, bus_a.valid_out, bus_a.sel_out, bus_a.data_out, exp_sel, exp_dat);
            end
        end
    endtask

    task automatic test_burst_lock();
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 64'h11);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0010) begin
            errors++;
            $display("FAIL burst_sop_ready got=%b want=0010", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.sel_out !== 2'd1 || bus_a.data_out !== 64'h11 || bus_a.sop_out !== 1'b1 ||
            bus_a.eop_out !== 1'b0 || bus_a.locked !== 1'b1) begin
            errors++;
            $display("FAIL burst_sop_out sel=%0d data=%h sop=%b eop=%b locked=%b want 1 11 1 0 1",
                     bus_a.sel_out, bus_a.data_out, bus_a.sop_out, bus_a.eop_out, bus_a.locked);
        end
        set_req(1, 1'b1, 1'b0, 1'b0, 64'h12);
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h01);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0010) begin
            errors++;
            $display("FAIL burst_mid_ready got=%b want=0010", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.sel_out !== 2'd1 || bus_a.data_out !== 64'h12 || bus_a.locked !== 1'b1) begin
            errors++;
            $display("FAIL burst_mid_out sel=%0d data=%h locked=%b want 1 12 1",
                     bus_a.sel_out, bus_a.data_out, bus_a.locked);
        end
        set_req(1, 1'b1, 1'b0, 1'b1, 64'h13);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0010) begin
            errors++;
            $display("FAIL burst_eop_ready got=%b want=0010", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.sel_out !== 2'd1 || bus_a.data_out !== 64'h13 || bus_a.eop_out !== 1'b1 ||
            bus_a.locked !== 1'b0) begin
            errors++;
            $display("FAIL burst_eop_out sel=%0d data=%h eop=%b locked=%b want 1 13 1 0",
                     bus_a.sel_out, bus_a.data_out, bus_a.eop_out, bus_a.locked);
        end
        set_req(1, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0001) begin
            errors++;
            $display("FAIL burst_after_ready got=%b want=0001", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.sel_out !== 2'd0 || bus_a.data_out !== 64'h01) begin
            errors++;
            $display("FAIL burst_after_out sel=%0d data=%h want 0 01",
                     bus_a.sel_out, bus_a.data_out);
        end
    endtask

    task automatic test_lock_wait();
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 64'h21);
        tick();
        set_req(1, 1'b0, 1'b0, 1'b0, 64'h0);
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h01);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus_a.ready_in[0] !== 1'b0) begin
                errors++;
                $display("FAIL wait_ready0 k=%0d got=%b want=0", k, bus_a.ready_in[0]);
            end
            tick();
            checks++;
            if (bus_a.locked !== 1'b1 || bus_a.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL wait_state k=%0d locked=%b valid=%b want 1 0",
                         k, bus_a.locked, bus_a.valid_out);
            end
        end
        set_req(1, 1'b1, 1'b0, 1'b1, 64'h22);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0010) begin
            errors++;
            $display("FAIL wait_resume_ready got=%b want=0010", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.sel_out !== 2'd1 || bus_a.data_out !== 64'h22 || bus_a.eop_out !== 1'b1 ||
            bus_a.locked !== 1'b0) begin
            errors++;
            $display("FAIL wait_resume_out sel=%0d data=%h eop=%b locked=%b want 1 22 1 0",
                     bus_a.sel_out, bus_a.data_out, bus_a.eop_out, bus_a.locked);
        end
        set_req(1, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0001) begin
            errors++;
            $display("FAIL wait_after_ready got=%b want=0001", bus_a.ready_in);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h41);
        tick();
        checks++;
        if (bus_a.valid_out !== 1'b1 || bus_a.data_out !== 64'h41) begin
            errors++;
            $display("FAIL bp_first valid=%b data=%h want 1 41", bus_a.valid_out, bus_a.data_out);
        end
        bus_a.ready_out = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h42);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus_a.ready_in !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready k=%0d got=%b want=0000", k, bus_a.ready_in);
            end
            tick();
            checks++;
            if (bus_a.valid_out !== 1'b1 || bus_a.data_out !== 64'h41 || bus_a.sel_out !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold k=%0d valid=%b data=%h sel=%0d want 1 41 0",
                         k, bus_a.valid_out, bus_a.data_out, bus_a.sel_out);
            end
        end
        bus_a.ready_out = 1'b1;
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready got=%b want=0001", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.valid_out !== 1'b1 || bus_a.data_out !== 64'h42) begin
            errors++;
            $display("FAIL bp_release_out valid=%b data=%h want 1 42",
                     bus_a.valid_out, bus_a.data_out);
        end
    endtask

    // Req3 saturates while req1 holds the lock; reset must drop the lock and clear req3's count.
    task automatic test_reset_mid_burst();
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 64'h51);
        tick();
        set_req(1, 1'b0, 1'b0, 1'b0, 64'h0);
        set_req(3, 1'b1, 1'b1, 1'b1, 64'h53);
        repeat (15) tick();
        set_req(1, 1'b1, 1'b0, 1'b0, 64'h52);
        tick();
        checks++;
        if (bus_a.valid_out !== 1'b1 || bus_a.locked !== 1'b1 || bus_a.data_out !== 64'h52) begin
            errors++;
            $display("FAIL rst_pre valid=%b locked=%b data=%h want 1 1 52",
                     bus_a.valid_out, bus_a.locked, bus_a.data_out);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus_a.valid_out !== 1'b0 || bus_a.locked !== 1'b0 || bus_a.sel_out !== 2'd0 ||
            bus_a.data_out !== 64'd0 || bus_a.sop_out !== 1'b0 || bus_a.eop_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid valid=%b locked=%b sel=%0d data=%h sop=%b eop=%b want all 0",
                     bus_a.valid_out, bus_a.locked, bus_a.sel_out, bus_a.data_out,
                     bus_a.sop_out, bus_a.eop_out);
        end
        reset = 1'b0;
        set_req(1, 1'b0, 1'b0, 1'b0, 64'h0);
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h50);
        #1;
        checks++;
        if (bus_a.ready_in !== 4'b0001) begin
            errors++;
            $display("FAIL rst_after_ready got=%b want=0001", bus_a.ready_in);
        end
        tick();
        checks++;
        if (bus_a.sel_out !== 2'd0 || bus_a.data_out !== 64'h50) begin
            errors++;
            $display("FAIL rst_after_out sel=%0d data=%h want 0 50",
                     bus_a.sel_out, bus_a.data_out);
        end
    endtask

    task automatic test_single_req_stream();
        int sent;
        int rcvd;
        sent = 0;
        rcvd = 0;
        do_reset();
        for (int c = 0; c < 200 && rcvd < 10; c++) begin
            bus_b.valid_in[0] = (sent < 10);
            bus_b.sop_in[0]   = (sent == 0);
            bus_b.eop_in[0]   = (sent == 9);
            bus_b.data_in     = 64'(200 + sent);
            bus_b.ready_out   = (sent >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (bus_b.valid_out && bus_b.ready_out) begin
                checks++;
                if (bus_b.data_out !== 64'(200 + rcvd) || bus_b.sel_out !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_beat n=%0d data=%0d sel=%0d want %0d 0",
                             rcvd, bus_b.data_out, bus_b.sel_out, 200 + rcvd);
                end
                rcvd++;
            end
            if (bus_b.valid_in[0] && bus_b.ready_in[0]) sent++;
            tick();
        end
        bus_b.valid_in = '0;
        checks++;
        if (rcvd != 10 || sent != 10) begin
            errors++;
            $display("FAIL stream_count rcvd=%0d sent=%0d want 10 10", rcvd, sent);
        end
        checks++;
        if (bus_b.locked !== 1'b0) begin
            errors++;
            $display("FAIL stream_unlock locked=%b want 0", bus_b.locked);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_starvation();
        test_burst_lock();
        test_lock_wait();
        test_backpressure();
        test_reset_mid_burst();
        test_single_req_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
